// File: rtl/serial_subtractor_2b.sv
// serial_subtractor_2b
//   Digit-serial subtractor that computes A - B two bits per clock. It uses
//   one 2-bit adder slice on A + ~B + carry and starts with carry-in = 1.
//   The LSB digit goes first. The block also produces SLT/SLTU-style
//   compare flags.
//
//   Handshake semantics (both sides):
//   - A transfer happens on a rising edge where valid && ready.
//   - o_ready is high only in IDLE; o_valid is high only in DONE.
//   - While o_valid is high, o_diff/o_borrow/flags stay stable until the
//     consumer takes them.
//   - The result-accept edge never also accepts new operands, so there is a
//     one-cycle bubble: one op per WIDTH/2+2 cycles with i_ready held high.
//
//   Optional feature: define SERIAL_SUB_FLAGS_EN to build the o_zero, o_ovf,
//   o_lt and o_ltu flag logic. Without it those ports are tied to 0, and the
//   operand sign registers are not built.
//
// Parameters
//   WIDTH    operand width in bits (even, >= 2); WIDTH/2 cycles per op
// Ports
//   i_clk    clock, rising edge
//   i_rst_n  synchronous reset, active low
//   i_valid  operands valid            o_ready   operands accepted (IDLE)
//   i_a      minuend                   i_b       subtrahend
//   o_valid  result valid (DONE)       i_ready   consumer accepts result
//   o_diff   A - B mod 2^WIDTH         o_borrow  unsigned A < B
//   o_zero   diff == 0                 o_ovf     signed overflow
//   o_lt     signed A < B              o_ltu     unsigned A < B
//   o_state  FSM state (0 IDLE, 1 RUN, 2 DONE) for debug/checkers
module serial_subtractor_2b #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_diff,
  output logic             o_borrow,
  output logic             o_zero,
  output logic             o_ovf,
  output logic             o_lt,
  output logic             o_ltu,
  output logic [1:0]       o_state
);

  // The counter must be at least one bit wide, even when WIDTH == 2.
  localparam int CW = (WIDTH / 2 > 1) ? $clog2(WIDTH / 2) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH / 2 - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] nb_sh;
  logic [WIDTH-1:0] diff_sh;
  logic [WIDTH-1:0] diff_q;
  logic             borrow_q;

  // One 2-bit slice of A + ~B + carry; bit 2 is the carry out.
  logic [2:0]       slice;
  logic [WIDTH+1:0] diff_cat;
  logic [WIDTH-1:0] diff_nxt;
  logic             last_step;

  assign slice     = {1'b0, a_sh[1:0]} + {1'b0, nb_sh[1:0]} + {2'b00, carry};
  // Shift the new digit in from the top; this form also works for WIDTH == 2.
  assign diff_cat  = {slice[1:0], diff_sh};
  assign diff_nxt  = diff_cat[WIDTH+1:2];
  assign last_step = (state == RUN) && (cnt == LAST);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      carry    <= 1'b0;
      a_sh     <= '0;
      nb_sh    <= '0;
      diff_sh  <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_valid) begin
            a_sh  <= i_a;
            nb_sh <= ~i_b;
            carry <= 1'b1;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          a_sh    <= a_sh >> 2;
          nb_sh   <= nb_sh >> 2;
          diff_sh <= diff_nxt;
          carry   <= slice[2];
          cnt     <= cnt + CW'(1);
          if (cnt == LAST) begin
            diff_q   <= diff_nxt;
            borrow_q <= ~slice[2];
            state    <= DONE;
          end
        end
        DONE: begin
          if (i_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_ready  = (state == IDLE);
  assign o_valid  = (state == DONE);
  assign o_diff   = diff_q;
  assign o_borrow = borrow_q;
  assign o_state  = state;

`ifdef SERIAL_SUB_FLAGS_EN
  logic a_msb;
  logic b_msb;
  logic zero_q;
  logic ovf_q;
  logic lt_q;
  logic ltu_q;
  logic ovf_nxt;

  // Overflow happens when the operand signs differ and the result sign
  // differs from the sign of A.
  assign ovf_nxt = (a_msb != b_msb) && (diff_nxt[WIDTH-1] != a_msb);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      zero_q <= 1'b0;
      ovf_q  <= 1'b0;
      lt_q   <= 1'b0;
      ltu_q  <= 1'b0;
    end else if (state == IDLE && i_valid) begin
      a_msb <= i_a[WIDTH-1];
      b_msb <= i_b[WIDTH-1];
    end else if (last_step) begin
      zero_q <= (diff_nxt == '0);
      ovf_q  <= ovf_nxt;
      lt_q   <= diff_nxt[WIDTH-1] ^ ovf_nxt;
      ltu_q  <= ~slice[2];
    end
  end

  assign o_zero = zero_q;
  assign o_ovf  = ovf_q;
  assign o_lt   = lt_q;
  assign o_ltu  = ltu_q;
`else
  logic unused_last_step;
  assign unused_last_step = last_step;
  assign o_zero = 1'b0;
  assign o_ovf  = 1'b0;
  assign o_lt   = 1'b0;
  assign o_ltu  = 1'b0;
`endif

endmodule

// File: tb/tb_serial_subtractor_2b.sv
// Bench for serial_subtractor_2b.
// It drives a 32-bit instance with directed vectors and a 2-bit instance with
// all 16 operand pairs. Expected values are hand-computed constants, plus a
// tiny 2-bit model.
module tb_serial_subtractor_2b;

`ifdef SERIAL_SUB_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- 32-bit instance ----------------
  logic        i_valid = 1'b0;
  logic        i_ready = 1'b0;
  logic [31:0] i_a = '0;
  logic [31:0] i_b = '0;
  logic        o_ready;
  logic        o_valid;
  logic [31:0] o_diff;
  logic        o_borrow;
  logic        o_zero;
  logic        o_ovf;
  logic        o_lt;
  logic        o_ltu;
  logic [1:0]  o_state;

  serial_subtractor_2b #(.WIDTH(32)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_a(i_a), .i_b(i_b), .o_valid(o_valid), .i_ready(i_ready),
    .o_diff(o_diff), .o_borrow(o_borrow), .o_zero(o_zero), .o_ovf(o_ovf),
    .o_lt(o_lt), .o_ltu(o_ltu), .o_state(o_state)
  );

  // ---------------- 2-bit instance ----------------
  logic       v2 = 1'b0;
  logic       r2_in = 1'b1;
  logic [1:0] a2 = '0;
  logic [1:0] b2 = '0;
  logic       rdy2;
  logic       val2;
  logic [1:0] diff2;
  logic       bor2;
  logic       z2;
  logic       ov2;
  logic       lt2;
  logic       ltu2;
  logic [1:0] st2;

  serial_subtractor_2b #(.WIDTH(2)) dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(v2), .o_ready(rdy2),
    .i_a(a2), .i_b(b2), .o_valid(val2), .i_ready(r2_in),
    .o_diff(diff2), .o_borrow(bor2), .o_zero(z2), .o_ovf(ov2),
    .o_lt(lt2), .o_ltu(ltu2), .o_state(st2)
  );

  // ---------------- scoreboard counters ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Present operands and return at the negedge after the accept edge.
  task automatic accept(input logic [31:0] a, input logic [31:0] b);
    int t;
    t = 0;
    @(negedge clk);
    while (!o_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("ready_before_accept", {31'b0, o_ready}, 32'd1);
    i_valid = 1'b1;
    i_a = a;
    i_b = b;
    @(posedge clk);
    @(negedge clk);
    i_valid = 1'b0;
    check("busy_after_accept", {31'b0, o_ready}, 32'd0);
  endtask

  // Count the rising edges from accept until o_valid, bounded.
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!o_valid && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic run_vec(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_d, input logic exp_bor,
                         input logic [3:0] exp_flags);
    int lat;
    accept(a, b);
    wait_valid(lat);
    check({tag, "_latency"}, lat, 32'd16);
    check({tag, "_diff"}, o_diff, exp_d);
    check({tag, "_borrow"}, {31'b0, o_borrow}, {31'b0, exp_bor});
    check({tag, "_flags_zolu"}, {28'b0, o_zero, o_ovf, o_lt, o_ltu},
          {28'b0, exp_flags & {4{FLAGS}}});
    i_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i_ready = 1'b0;
    check({tag, "_idle_after"}, {30'b0, o_ready, o_valid}, 32'b10);
  endtask

  // Watchdog: every wait is bounded, so this only catches a broken bench.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [1:0] d;
    logic [3:0] fl;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_state", {26'b0, o_state, o_ready, o_valid, o_borrow, o_zero},
          {26'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0});
    check("reset_diff", o_diff, 32'd0);
    check("reset_flags", {29'b0, o_ovf, o_lt, o_ltu}, 32'd0);
    rst_n = 1'b1;

    // flags argument is {zero, ovf, lt, ltu}
    run_vec("5m3",  32'd5, 32'd3, 32'h0000_0002, 1'b0, 4'b0000);
    run_vec("3m5",  32'd3, 32'd5, 32'hFFFF_FFFE, 1'b1, 4'b0011);
    run_vec("eq",   32'h1234_5678, 32'h1234_5678, 32'h0, 1'b0, 4'b1000);
    run_vec("minm1", 32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 1'b0, 4'b0110);
    run_vec("maxmn", 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 4'b0101);
    run_vec("0m1",  32'h0, 32'h1, 32'hFFFF_FFFF, 1'b1, 4'b0011);
    run_vec("dead", 32'hDEAD_BEEF, 32'h1234_5678, 32'hCC79_6877, 1'b0, 4'b0010);

    // Backpressure: the result holds while new operand pulses are ignored.
    accept(32'd5, 32'd3);
    wait_valid(lat);
    check("bp_latency", lat, 32'd16);
    for (int i = 0; i < 5; i++) begin
      i_valid = 1'(i & 1);
      i_a = $urandom_range(0, 1000);
      i_b = $urandom_range(0, 1000);
      @(posedge clk);
      @(negedge clk);
      check("bp_hold_valid_ready", {30'b0, o_valid, o_ready}, 32'b10);
      check("bp_hold_diff", o_diff, 32'd2);
    end
    // The result-accept edge must not also take the offered operands.
    i_valid = 1'b1;
    i_a = 32'd7;
    i_b = 32'd1;
    i_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i_valid = 1'b0;
    i_ready = 1'b0;
    check("bubble_state", {30'b0, o_state}, 32'd0);
    check("bubble_ready_valid", {30'b0, o_ready, o_valid}, 32'b10);

    // Reset in the middle of RUN: the op is aborted and the result cleared.
    accept(32'd100, 32'd1);
    repeat (7) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_ready_valid", {30'b0, o_ready, o_valid}, 32'b10);
    check("midrst_diff", o_diff, 32'd0);
    check("midrst_borrow", {31'b0, o_borrow}, 32'd0);
    run_vec("9m4", 32'd9, 32'd4, 32'd5, 1'b0, 4'b0000);

    // WIDTH=2 exhaustive, i_ready held high; the result appears one edge after accept.
    for (int a = 0; a < 4; a++) begin
      for (int b = 0; b < 4; b++) begin
        @(negedge clk);
        check("w2_ready", {31'b0, rdy2}, 32'd1);
        v2 = 1'b1;
        a2 = 2'(a);
        b2 = 2'(b);
        @(posedge clk);
        @(negedge clk);
        v2 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        d = 2'(a - b);
        fl[3] = (d == 2'd0);
        fl[2] = (a2[1] != b2[1]) && (d[1] != a2[1]);
        fl[1] = d[1] ^ fl[2];
        fl[0] = (a < b);
        check("w2_valid", {31'b0, val2}, 32'd1);
        check("w2_diff", {30'b0, diff2}, {30'b0, d});
        check("w2_borrow", {31'b0, bor2}, {31'b0, (a < b)});
        check("w2_flags", {28'b0, z2, ov2, lt2, ltu2}, {28'b0, fl & {4{FLAGS}}});
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
